ulpi_capture_buffer: RTL and testbench
======================================

# ulpi_capture_buffer

Packet-framing capture FIFO between the ULPI receive path and the byte-serial host link (UART/SPI drain) of the USB3300 sniffer. Each received USB packet is wrapped as: header byte, optional timestamp, payload, trailer. The frame goes into a parametrised-depth FIFO, and a first-word-fall-through valid/ready port drains it. Compared with the fixed, unframed datapath of the current sniffer top, this block adds overflow-safe framing, space reservation, drop accounting and an optional timestamp.

## Interface
Parameters:
- DEPTH_BITS, 9: FIFO depth = 2^DEPTH_BITS bytes; legal range 4..12.
- TS_BYTES, 4: timestamp width in bytes (1..4); used only with USB_CAPTURE_TIMESTAMP_EN.

Ports:
- clk  in  1  single clock for all logic (ULPI 60 MHz domain)
- rst  in  1  synchronous, active-high reset
- capture_en  in  1  permits new packets to start; a packet in progress always completes
- rx_active  in  1  high while a USB packet is being received
- rx_valid  in  1  rx_data holds a payload byte this cycle
- rx_data  in  8  payload byte
- out_ready  in  1  consumer accepts out_data this cycle
- out_valid  out  1  FIFO non-empty
- out_data  out  8  byte at FIFO head
- fifo_level  out  DEPTH_BITS+1  bytes currently stored
- overflow  out  1  sticky: set on any dropped byte or skipped packet; cleared only by rst

## Operation
- States: IDLE, TS, DATA, TRL, SKIP. H = 1 + TS_BYTES with the macro, otherwise 1. free = 2^DEPTH_BITS − fifo_level.
- armed flag: cleared by rst; set in any IDLE cycle with rx_active=0. This prevents capturing a packet whose start was missed.
- IDLE with armed & capture_en & rx_active:
  - If free ≥ H+1: push 0xA5, latch the timestamp counter, clear len and drop_flag, then go to TS (macro on) or DATA.
  - Otherwise: push nothing, set overflow, go to SKIP.
- rx_valid in IDLE or SKIP: ignored.
- TS: push one latched timestamp byte per cycle, MSB first, for TS_BYTES cycles, then go to DATA. An rx_valid byte during TS is dropped and sets drop_flag and overflow. If rx_active falls during TS, the remaining TS bytes are still pushed, then the state is TRL.
- DATA, rx_valid=1:
  - If free ≥ 2: push rx_data; len = min(len+1, 127).
  - Otherwise: drop the byte; set drop_flag and overflow.
  - One slot is always reserved for the trailer.
- DATA with rx_active=0 goes to TRL. A byte with rx_valid=1 in that same cycle is still processed.
- TRL: push {drop_flag, len[6:0]}, then go to IDLE. The trailer push can never fail.
- SKIP: stay until rx_active=0, then go to IDLE.
- Read side:
  - out_valid = (fifo_level ≠ 0); out_data = mem[rd_ptr].
  - Pop on out_valid & out_ready.
  - A push and a pop in the same cycle are both performed, and fifo_level is unchanged.
- Pointers are DEPTH_BITS wide and wrap modulo depth. fifo_level is computed exactly; it is never derived from wrapped pointers alone.

## Timing
- Reset values: out_valid=0, fifo_level=0, overflow=0, state=IDLE, armed=0, pointers=0, timestamp counter=0. out_data is don't-care while out_valid=0.
- Push to out_valid latency is 1 cycle (write at edge N; visible after edge N+1). A pop takes effect at the same edge.
- With the macro on, the first payload byte can be stored no earlier than TS_BYTES+1 cycles after the header cycle.
- rst mid-packet discards all FIFO contents and the partial frame. Capture resumes only after rx_active is seen low.
- The timestamp counter is TS_BYTES×8 bits, increments every clk, and wraps to 0.

## Configuration
- USB_CAPTURE_TIMESTAMP_EN defined:
  - TS state, timestamp counter and latch are present.
  - Frame = A5, TS_BYTES timestamp bytes, payload, trailer.
  - H = TS_BYTES+1.
- Undefined:
  - No counter, no TS state; IDLE goes directly to DATA.
  - Frame = A5, payload, trailer.
  - H = 1; TS_BYTES is ignored.

## Test plan
- Macro off, out_ready=1, rx_active high for 5 cycles with bytes 11,22,33 -> out stream A5 11 22 33 03; overflow=0.
- Macro on, TS_BYTES=2, counter=0x0123 at packet start, payload 44 -> out stream A5 01 23 44 01.
- DEPTH_BITS=4, out_ready=0, macro off, 20-byte packet -> 14 payload bytes stored; trailer 0x8E; fifo_level=16; overflow=1.
- Continuing that full FIFO, a second packet starts -> SKIP, no bytes pushed, fifo_level stays 16; the next packet after draining is captured normally.
- Macro on, TS_BYTES=4, rx_valid asserted during the TS state -> that byte is absent from the output; trailer bit7=1.
- rst asserted mid-packet while rx_active stays high -> fifo_level=0, out_valid=0, no header emitted until rx_active goes low, then high again.

Source files
------------

// File: rtl/ulpi_capture_buffer.sv
// ulpi_capture_buffer
// Frames each received ULPI packet as A5 header, optional timestamp, payload
// and trailer {drop_flag, len[6:0]}. The frame is stored in a 2^DEPTH_BITS byte
// FIFO that is drained through a first-word-fall-through valid/ready port.
// Define USB_CAPTURE_TIMESTAMP_EN to insert TS_BYTES timestamp bytes (MSB first)
// after the header. Without it, the counter and the TS state are not built.
module ulpi_capture_buffer #(
  parameter int DEPTH_BITS = 9,
  parameter int TS_BYTES   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture_en,
  input  logic                  rx_active,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  output logic [DEPTH_BITS:0]   fifo_level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_BITS;
`ifdef USB_CAPTURE_TIMESTAMP_EN
  localparam int TS_EN = 1;
`else
  localparam int TS_EN = 0;
`endif
  // Header length H: A5 plus the timestamp bytes when they are built in
  localparam int HDR_LEN = 1 + TS_EN * TS_BYTES;

  localparam logic [DEPTH_BITS:0]   DEPTH_LVL  = (DEPTH_BITS+1)'(DEPTH);
  // A packet may start only if the header and its trailer both fit
  localparam logic [DEPTH_BITS:0]   START_NEED = (DEPTH_BITS+1)'(HDR_LEN + 1);
  // A payload byte may be stored only if one slot stays free for the trailer
  localparam logic [DEPTH_BITS:0]   DATA_NEED  = (DEPTH_BITS+1)'(2);
  localparam logic [DEPTH_BITS:0]   LVL_ONE    = (DEPTH_BITS+1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE    = DEPTH_BITS'(1);
  localparam logic [7:0]            HDR_BYTE   = 8'hA5;
  localparam logic [6:0]            LEN_MAX    = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TS   = 3'd1,
    S_DATA = 3'd2,
    S_TRL  = 3'd3,
    S_SKIP = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  overflow_q, overflow_d;
  logic [6:0]            len_q, len_d;
  logic                  drop_q, drop_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_BITS:0]   level_q, level_d;
  logic [DEPTH_BITS:0]   free;
  logic                  push;
  logic [7:0]            push_data;
  logic                  pop;
  logic [7:0]            mem [DEPTH];

`ifdef USB_CAPTURE_TIMESTAMP_EN
  localparam int         TS_W    = TS_BYTES * 8;
  localparam logic [1:0] TS_LAST = 2'(TS_BYTES - 1);

  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] ts_sh_q, ts_sh_d;
  logic [1:0]      ts_idx_q, ts_idx_d;
  // Remembers that rx_active fell while the timestamp was still being emitted
  logic            ts_end_q, ts_end_d;

  // Free-running timestamp counter, wraps to zero
  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
  end
`endif

  assign free       = DEPTH_LVL - level_q;
  assign out_valid  = (level_q != '0);
  assign out_data   = mem[rd_ptr_q];
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign pop        = out_valid & out_ready;

  // Framing FSM: decides what (if anything) is pushed this cycle
  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    overflow_d = overflow_q;
    len_d      = len_q;
    drop_d     = drop_q;
    push       = 1'b0;
    push_data  = 8'h00;
`ifdef USB_CAPTURE_TIMESTAMP_EN
    ts_sh_d    = ts_sh_q;
    ts_idx_d   = ts_idx_q;
    ts_end_d   = ts_end_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (!rx_active) begin
          armed_d = 1'b1;
        end else if (armed_q && capture_en) begin
          if (free >= START_NEED) begin
            push      = 1'b1;
            push_data = HDR_BYTE;
            len_d     = '0;
            drop_d    = 1'b0;
`ifdef USB_CAPTURE_TIMESTAMP_EN
            ts_sh_d   = ts_cnt_q;
            ts_idx_d  = '0;
            ts_end_d  = 1'b0;
            state_d   = S_TS;
`else
            state_d   = S_DATA;
`endif
          end else begin
            overflow_d = 1'b1;
            state_d    = S_SKIP;
          end
        end
      end
      S_TS: begin
`ifdef USB_CAPTURE_TIMESTAMP_EN
        // Space for the whole header was reserved at packet start
        push      = 1'b1;
        push_data = ts_sh_q[TS_W-1 -: 8];
        ts_sh_d   = ts_sh_q << 8;
        if (rx_valid) begin
          drop_d     = 1'b1;
          overflow_d = 1'b1;
        end
        if (!rx_active) ts_end_d = 1'b1;
        if (ts_idx_q == TS_LAST) begin
          state_d = (ts_end_q || !rx_active) ? S_TRL : S_DATA;
        end else begin
          ts_idx_d = ts_idx_q + 2'd1;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_DATA: begin
        if (rx_valid) begin
          if (free >= DATA_NEED) begin
            push      = 1'b1;
            push_data = rx_data;
            len_d     = (len_q == LEN_MAX) ? len_q : len_q + 7'd1;
          end else begin
            drop_d     = 1'b1;
            overflow_d = 1'b1;
          end
        end
        if (!rx_active) state_d = S_TRL;
      end
      S_TRL: begin
        // The reserved slot guarantees this push always fits
        push      = 1'b1;
        push_data = {drop_q, len_q};
        state_d   = S_IDLE;
      end
      S_SKIP: begin
        if (!rx_active) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO bookkeeping: pointers wrap, level tracks push/pop exactly
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LVL_ONE;
    end else if (pop && !push) begin
      level_d = level_q - LVL_ONE;
    end
  end

  // Control state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      armed_q    <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
    end
  end

  // Per-frame trailer fields, always initialised by the header cycle
  always_ff @(posedge clk) begin
    len_q  <= len_d;
    drop_q <= drop_d;
  end

`ifdef USB_CAPTURE_TIMESTAMP_EN
  // Timestamp counter and emission progress
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_idx_q <= '0;
      ts_end_q <= 1'b0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_idx_q <= ts_idx_d;
      ts_end_q <= ts_end_d;
    end
  end

  // Latched timestamp, shifted out one byte per TS cycle
  always_ff @(posedge clk) begin
    ts_sh_q <= ts_sh_d;
  end
`endif

  // Byte storage write port
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_ulpi_capture_buffer.sv
// Scoreboard bench for ulpi_capture_buffer (DEPTH_BITS=4, TS_BYTES=2).
// Stimulus pushes hand-computed frame bytes into exp_q; the monitor pops and
// compares whenever a byte is handed over on the output port.
module tb_ulpi_capture_buffer;

  logic       clk;
  logic       rst;
  logic       capture_en;
  logic       rx_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [4:0] fifo_level;
  logic       overflow;

  int checks;
  int errors;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  ulpi_capture_buffer #(.DEPTH_BITS(4), .TS_BYTES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .capture_en (capture_en),
    .rx_active  (rx_active),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every accepted byte must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte got %02h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_data", {24'h0, out_data}, {24'h0, mon_exp});
      end
    end
  end

  task automatic drive(input logic a, input logic v, input logic [7:0] d);
    rx_active = a;
    rx_valid  = v;
    rx_data   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_active = 1'b0;
    rx_valid  = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_valid", {31'h0, out_valid}, 0);
    check("drain_level", {27'h0, fifo_level}, 0);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    capture_en = 1'b1;
    out_ready  = 1'b1;
    do_reset();
    check("reset_out_valid", {31'h0, out_valid}, 0);
    check("reset_level", {27'h0, fifo_level}, 0);
    check("reset_overflow", {31'h0, overflow}, 0);

`ifdef USB_CAPTURE_TIMESTAMP_EN
    // Header latches 0x0123: header cycle is sampled 0x124 edges after reset
    repeat (12'h123) drive(1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h01); exp_q.push_back(8'h23);
    exp_q.push_back(8'h44); exp_q.push_back(8'h01);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h44);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drain();
    check("ts_overflow_clear", {31'h0, overflow}, 0);

    // Byte during TS is dropped and flagged; timestamp 0x000A
    do_reset();
    repeat (10) drive(1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h55); exp_q.push_back(8'h81);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h77);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h55);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drain();
    check("ts_drop_overflow", {31'h0, overflow}, 1);
`else
    // Basic frame A5 11 22 33 03
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'h33); exp_q.push_back(8'h03);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h11);
    drive(1'b1, 1'b1, 8'h22);
    drive(1'b1, 1'b1, 8'h33);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drain();
    check("basic_overflow", {31'h0, overflow}, 0);

    // Byte arriving in the cycle rx_active falls is still stored
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    exp_q.push_back(8'h02);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h5A);
    drive(1'b0, 1'b1, 8'hC3);
    drive(1'b0, 1'b0, 8'h00);
    drain();

    // capture_en low: packet ignored, no overflow
    capture_en = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'hEE);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("capoff_level", {27'h0, fifo_level}, 0);
    check("capoff_overflow", {31'h0, overflow}, 0);
    capture_en = 1'b1;

    // Fill: 20-byte packet into 16-byte FIFO, 14 stored, trailer 8E
    out_ready = 1'b0;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 14; i++) exp_q.push_back(8'(8'h40 + i));
    exp_q.push_back(8'h8E);
    drive(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) drive(1'b1, 1'b1, 8'(8'h40 + i));
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("full_level", {27'h0, fifo_level}, 16);
    check("full_overflow", {31'h0, overflow}, 1);
    check("full_out_valid", {31'h0, out_valid}, 1);

    // Packet while full is skipped entirely
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h99);
    drive(1'b1, 1'b1, 8'h98);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    check("skip_level", {27'h0, fifo_level}, 16);
    drain();

    // After draining, the next packet is captured normally
    exp_q.push_back(8'hA5); exp_q.push_back(8'hAB); exp_q.push_back(8'h01);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'hAB);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drain();
    check("sticky_overflow", {31'h0, overflow}, 1);

    // Reset mid-packet with rx_active held high
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h12);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    drive(1'b1, 1'b1, 8'h34);
    drive(1'b1, 1'b1, 8'h35);
    drive(1'b1, 1'b0, 8'h00);
    check("rst_mid_level", {27'h0, fifo_level}, 0);
    check("rst_mid_out_valid", {31'h0, out_valid}, 0);
    check("rst_mid_overflow", {31'h0, overflow}, 0);
    out_ready = 1'b1;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h66); exp_q.push_back(8'h01);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 8'h66);
    drive(1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 8'h00);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
